fifo_rd_stream: RTL and testbench

- Read-side consumer for the async FIFO (`fifo_top`). Runs entirely in the read clock domain.
- Drives the FIFO's `rd_en`, captures its registered `data_out`, and re-presents the words as a valid/ready stream to downstream logic.
- A 2-entry output buffer sustains one word per cycle despite the FIFO's 1-cycle read latency. It also guarantees `rd_en` is never issued while `empty` is high.

---
 rtl/fifo_rd_stream.sv | 135 +++++++++++++
 tb/tb_fifo_rd_stream.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO: issues rd_en, captures data_out and re-presents it as a valid/ready stream.
// Optional statistics counters are built when FIFO_RD_STREAM_STATS_EN is defined.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_rd,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  state_e                state_q;
  logic [1:0]            occ_q;
  logic [1:0]            occ_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] head_d;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [DATA_WIDTH-1:0] tail_d;
  logic                  pop_s;
  logic [1:0]            occ_after_pop_s;
  logic [2:0]            level_s;

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = head_q;
  assign busy    = (state_q == ST_STREAM) || (state_q == ST_DRAIN);

  // Read request: level counts buffered plus in-flight words after this cycle's pop, so the buffer never overflows.
  always_comb begin
    pop_s           = m_valid & m_ready;
    occ_after_pop_s = occ_q - {1'b0, pop_s};
    level_s         = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    rd_en           = (state_q == ST_STREAM) & en & ~empty & (level_s < 3'd2);
  end

  // Buffer next state: head shifts on pop, the returning word lands in the first free slot.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = level_s[1:0];
    if (pop_s) begin
      head_d = tail_q;
    end else begin
      head_d = head_q;
    end
    if (inflight_q) begin
      if (occ_after_pop_s == 2'd0) begin
        head_d = data_out;
      end else begin
        tail_d = data_out;
      end
    end else begin
      tail_d = tail_q;
    end
  end

  // Buffer storage, occupancy and in-flight tracking.
  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= {DATA_WIDTH{1'b0}};
      tail_q     <= {DATA_WIDTH{1'b0}};
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= rd_en;
    end
  end

  // Control FSM; DRAIN keeps delivering buffered and in-flight words before returning to IDLE.
  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) state_q <= ST_STREAM;
          else    state_q <= ST_IDLE;
        end
        ST_STREAM: begin
          if (!en) state_q <= ST_DRAIN;
          else     state_q <= ST_STREAM;
        end
        ST_DRAIN: begin
          if (en)                                   state_q <= ST_STREAM;
          else if ((occ_q == 2'd0) && !inflight_q)  state_q <= ST_IDLE;
          else                                      state_q <= ST_DRAIN;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [CNT_WIDTH-1:0] rd_count_q;
  logic [CNT_WIDTH-1:0] stall_count_q;

  // Delivery and back-pressure counters, wrapping naturally.
  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q    <= {CNT_WIDTH{1'b0}};
      stall_count_q <= {CNT_WIDTH{1'b0}};
    end else begin
      if (pop_s) rd_count_q <= rd_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      else       rd_count_q <= rd_count_q;
      if (m_valid && !m_ready) stall_count_q <= stall_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      else                     stall_count_q <= stall_count_q;
    end
  end

  assign rd_count    = rd_count_q;
  assign stall_count = stall_count_q;
`else
  assign rd_count    = {CNT_WIDTH{1'b0}};
  assign stall_count = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural registered-output FIFO feeding it.
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int CW = 16;
`ifdef FIFO_RD_STREAM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk_rd = 1'b0;
  logic          rst_n;
  logic          en;
  logic          empty;
  logic [DW-1:0] data_out = '0;
  logic          rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          busy;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] stall_count;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_rd(clk_rd), .rst_n(rst_n), .en(en), .empty(empty), .data_out(data_out),
    .rd_en(rd_en), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .rd_count(rd_count), .stall_count(stall_count)
  );

  always #5 clk_rd = ~clk_rd;

  // FIFO model: registered read data, pointer-based empty
  logic [DW-1:0] mem [0:255];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          force_empty = 1'b0;
  assign empty = force_empty | (rd_ptr == wr_ptr);

  always @(posedge clk_rd) begin
    if (rd_en) begin
      data_out <= mem[rd_ptr[7:0]];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk_rd) cyc <= cyc + 1;

  logic [DW-1:0] rcv[$];
  int            rcv_cyc[$];
  int            rden_n = 0;
  int            viol = 0;

  always @(negedge clk_rd) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        rcv.push_back(m_data);
        rcv_cyc.push_back(cyc);
      end
      if (rd_en) rden_n++;
      if (rd_en && empty) viol++;
      if (dut.occ_q > 2'd2) viol++;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_rd);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    m_ready = 1'b0;
    force_empty = 1'b0;
    tick();
    tick();
    @(negedge clk_rd);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int base_r;
    int t_rden;
    int t_val;
    int n;
    int bad;

    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0;
    #2;
    check("rst_m_valid", m_valid, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_m_data", m_data, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_stall_count", stall_count, 0);

    // Test 1: three preloaded words at full rate
    do_reset();
    push(8'h11); push(8'h22); push(8'h33);
    base = rcv.size();
    en = 1'b1; m_ready = 1'b1;
    t_rden = -1; t_val = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rd_en && t_rden < 0) t_rden = cyc;
      if (m_valid && t_val < 0) t_val = cyc;
    end
    check("t1_latency", t_val - t_rden, 2);
    check("t1_count", rcv.size() - base, 3);
    check("t1_w0", rcv[base], 8'h11);
    check("t1_w1", rcv[base+1], 8'h22);
    check("t1_w2", rcv[base+2], 8'h33);
    check("t1_back_to_back", rcv_cyc[base+2] - rcv_cyc[base], 2);
    check("t1_rd_count", rd_count, STATS ? 3 : 0);

    // Test 2: FIFO stays empty
    do_reset();
    force_empty = 1'b1;
    base_r = rden_n;
    en = 1'b1; m_ready = 1'b1;
    repeat (20) tick();
    check("t2_no_rd_en", rden_n - base_r, 0);
    check("t2_m_valid", m_valid, 0);
    check("t2_busy", busy, 1);
    en = 1'b0;
    repeat (3) tick();
    check("t2_idle", busy, 0);
    force_empty = 1'b0;

    // Test 3: back-pressure for 10 cycles with 8 words available
    do_reset();
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    base = rcv.size();
    base_r = rden_n;
    en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_valid) break;
    end
    check("t3_valid_seen", m_valid, 1);
    check("t3_head_first", m_data, 8'hA0);
    repeat (10) tick();
    check("t3_rd_en_pulses", rden_n - base_r, 2);
    check("t3_head_held", m_data, 8'hA0);
    check("t3_stall_count", stall_count, STATS ? 10 : 0);
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rcv.size() - base >= 8) break;
    end
    repeat (3) tick();
    check("t3_count", rcv.size() - base, 8);
    bad = 0;
    for (int i = 0; i < 8; i++) if (rcv[base+i] !== 8'hA0 + 8'(i)) bad++;
    check("t3_order", bad, 0);

    // Test 4: en dropped after two reads of a 5-word burst
    do_reset();
    for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i));
    base = rcv.size();
    en = 1'b1; m_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_en) n++;
      if (n == 2) break;
    end
    tick();
    en = 1'b0;
    tick();
    check("t4_drain_state", dut.state_q, 2);
    check("t4_drain_busy", busy, 1);
    check("t4_drain_rd_en", rd_en, 0);
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      tick();
    end
    check("t4_idle", busy, 0);
    check("t4_count", rcv.size() - base, 2);
    check("t4_w0", rcv[base], 8'hB0);
    check("t4_w1", rcv[base+1], 8'hB1);
    check("t4_left_in_fifo", wr_ptr - rd_ptr, 3);

    // Test 5: reset while the buffer is full
    en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dut.occ_q == 2'd2) break;
    end
    check("t5_occ_full", dut.occ_q, 2);
    rst_n = 1'b0;
    #2;
    check("t5_rst_m_valid", m_valid, 0);
    check("t5_rst_rd_en", rd_en, 0);
    @(negedge clk_rd);
    rst_n = 1'b1;
    base = rcv.size();
    m_ready = 1'b1;
    repeat (15) tick();
    check("t5_count", rcv.size() - base, 1);
    check("t5_next_word", rcv[base], 8'hB4);

    // Test 6: m_ready toggling across 16 words
    do_reset();
    for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i));
    base = rcv.size();
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      m_ready = ~m_ready;
      if (rcv.size() - base >= 16) break;
    end
    m_ready = 1'b1;
    repeat (5) tick();
    check("t6_count", rcv.size() - base, 16);
    bad = 0;
    for (int i = 0; i < 16; i++) if (rcv[base+i] !== 8'hC0 + 8'(i)) bad++;
    check("t6_order", bad, 0);
    check("t6_invariants", viol, 0);
    en = 1'b0;
    repeat (3) tick();
    check("t6_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
